// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline hazard controller on the consumer side of the ID/EX register.
//   It watches the ID/EX outputs (memread, regwrite, destination register),
//   the IF/ID source-register fields, the EX-stage redirect and the data
//   memory busy flag. From these it drives stall, flush, bubble and hold
//   controls into the PC, IF/ID and ID/EX registers.
//
//   The outputs are Mealy: they are decided in the same cycle from the
//   current state plus the inputs, so the pipeline enables react with zero
//   latency. State is updated on the falling clock edge, which is the same
//   edge the pipeline registers use.
//
//   Priority in every state is mem_busy > redirect_ex > load-use.
//
// Parameters:
//   FLUSH_CYCLES : cycles if_id_flush stays high per redirect (1..7)
//   LOAD_LAT     : stall cycles per load-use hazard (1..7)
//   CNT_W        : performance counter width (only with HAZARD_PERF_CNT_EN)
//
// Ports:
//   clk            in   system clock, state updates on negedge
//   reset          in   asynchronous active-low reset
//   if_id_rs1      in   rs1 field of the instruction in ID
//   if_id_rs2      in   rs2 field of the instruction in ID
//   if_id_uses_rs2 in   instruction in ID reads rs2
//   id_ex_memread  in   MemRead output of ID/EX
//   id_ex_regwrite in   RegWrite output of ID/EX
//   id_ex_rd       in   destination register output of ID/EX
//   redirect_ex    in   EX resolved a taken branch / jal / jalr
//   mem_busy       in   data memory not ready, freeze the pipeline
//   pc_write       out  PC load enable
//   if_id_write    out  IF/ID load enable
//   if_id_flush    out  IF/ID loads a NOP
//   id_ex_bubble   out  ID/EX loads all-zero control
//   id_ex_hold     out  ID/EX keeps its contents
//   ctrl_state     out  current FSM state (RUN=0, LOAD_STALL=1,
//                       MEM_WAIT=2, FLUSH=3)
//   stall_count    out  cycles with pc_write low (HAZARD_PERF_CNT_EN only)
//   flush_count    out  cycles with if_id_flush high (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the two saturating
// performance counters. Without it the counters and their ports are absent.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int LOAD_LAT     = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_uses_rs2,
  input  logic       id_ex_memread,
  input  logic       id_ex_regwrite,
  input  logic [4:0] id_ex_rd,
  input  logic       redirect_ex,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       id_ex_hold,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;
  localparam logic [1:0] FLUSH      = 2'd3;

  // The detect cycle is spent in RUN, and the last extra cycle is the one
  // where cnt is 0, so the reload value is the total minus two.
  localparam logic [2:0] FLUSH_RELOAD =
    (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam logic [2:0] LOAD_RELOAD =
    (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic loadUse;
  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExBubble;
  logic idExHold;

  // A load in EX whose destination is read by the instruction in ID.
  // Writes to x0 are discarded by the register file, so they never stall.
  assign loadUse = id_ex_memread & id_ex_regwrite & (id_ex_rd != 5'd0) &
                   ((id_ex_rd == if_id_rs1) |
                    (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));

  // Next-state and raw output decode. mem_busy and redirect_ex are handled
  // the same way in every state, so they sit ahead of the state case.
  // MEM_WAIT with mem_busy low behaves exactly like RUN: the held ID/EX
  // contents let any load-use or redirect be rediscovered from scratch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    idExHold   = 1'b0;

    if (mem_busy) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExHold  = 1'b1;
      state_d   = MEM_WAIT;
      cnt_d     = 3'd0;
    end else if (redirect_ex) begin
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      case (state_q)
        LOAD_STALL: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        FLUSH: begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
          if (loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // While reset is low the pipeline runs freely whatever the inputs say.
  assign pc_write     = reset ? pcWrite    : 1'b1;
  assign if_id_write  = reset ? ifIdWrite  : 1'b1;
  assign if_id_flush  = reset ? ifIdFlush  : 1'b0;
  assign id_ex_bubble = reset ? idExBubble : 1'b0;
  assign id_ex_hold   = reset ? idExHold   : 1'b0;
  assign ctrl_state   = state_q;

  // State register, clocked on the falling edge like the pipeline registers.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters of frozen-PC cycles and flush cycles.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (if_id_flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Drives three instances of hazard_control_unit with different FLUSH_CYCLES /
// LOAD_LAT settings from one shared stimulus stream. A behavioural model
// tracks, per instance, how many extra stall or flush cycles are still owed
// and whether the pipeline is frozen on memory, and predicts every output.
// Directed sequences with literal expectations come first, then a long
// randomized run.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic       hold;
    logic [1:0] st;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       usesRs2;
  logic       memread;
  logic       regwrite;
  logic [4:0] rd;
  logic       redirect;
  logic       memBusy;

  logic       pcw  [3];
  logic       ifw  [3];
  logic       fl   [3];
  logic       bub  [3];
  logic       hold [3];
  logic [1:0] st   [3];

  int fcTab[3] = '{2, 1, 4};
  int llTab[3] = '{3, 1, 2};

  int vectors    = 0;
  int miscompares = 0;

  // Model state: extra stall cycles owed, extra flush cycles owed, frozen.
  int sL[3]  = '{0, 0, 0};
  int fL[3]  = '{0, 0, 0};
  bit inM[3] = '{0, 0, 0};

`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] stallCnt [3];
  logic [1:0] flushCnt [3];
  int mStall[3] = '{0, 0, 0};
  int mFlush[3] = '{0, 0, 0};
`endif

  hazard_control_unit #(.FLUSH_CYCLES(2), .LOAD_LAT(3)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs2(usesRs2), .id_ex_memread(memread),
    .id_ex_regwrite(regwrite), .id_ex_rd(rd), .redirect_ex(redirect),
    .mem_busy(memBusy), .pc_write(pcw[0]), .if_id_write(ifw[0]),
    .if_id_flush(fl[0]), .id_ex_bubble(bub[0]), .id_ex_hold(hold[0]),
    .ctrl_state(st[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stallCnt[0]), .flush_count(flushCnt[0])
`endif
  );

  hazard_control_unit #(.FLUSH_CYCLES(1), .LOAD_LAT(1)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut1 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs2(usesRs2), .id_ex_memread(memread),
    .id_ex_regwrite(regwrite), .id_ex_rd(rd), .redirect_ex(redirect),
    .mem_busy(memBusy), .pc_write(pcw[1]), .if_id_write(ifw[1]),
    .if_id_flush(fl[1]), .id_ex_bubble(bub[1]), .id_ex_hold(hold[1]),
    .ctrl_state(st[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stallCnt[1]), .flush_count(flushCnt[1])
`endif
  );

  hazard_control_unit #(.FLUSH_CYCLES(4), .LOAD_LAT(2)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut2 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs2(usesRs2), .id_ex_memread(memread),
    .id_ex_regwrite(regwrite), .id_ex_rd(rd), .redirect_ex(redirect),
    .mem_busy(memBusy), .pc_write(pcw[2]), .if_id_write(ifw[2]),
    .if_id_flush(fl[2]), .id_ex_bubble(bub[2]), .id_ex_hold(hold[2]),
    .ctrl_state(st[2])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stallCnt[2]), .flush_count(flushCnt[2])
`endif
  );

  // Clock: negedge is the active edge of the design.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input bit p, input bit w, input bit f,
                               input bit b, input bit h, input logic [1:0] s);
    outs_t o;
    o = {p, w, f, b, h, s};
    return o;
  endfunction

  function automatic outs_t actual(input int i);
    outs_t o;
    o = {pcw[i], ifw[i], fl[i], bub[i], hold[i], st[i]};
    return o;
  endfunction

  function automatic bit luNow();
    return memread && regwrite && (rd != 5'd0) &&
           ((rd == rs1) || (usesRs2 && (rd == rs2)));
  endfunction

  // Reference rules: outputs this cycle and the owed-cycle counts after the
  // next falling edge.
  function automatic void evalModel(input int fc, input int ll,
                                    input int s, input int f, input bit m,
                                    input bit rstn, input bit busy,
                                    input bit redir, input bit lu,
                                    output outs_t o, output int ns,
                                    output int nf, output bit nm);
    o  = mk(1, 1, 0, 0, 0, 2'd0);
    o.st = m ? 2'd2 : (s > 0) ? 2'd1 : (f > 0) ? 2'd3 : 2'd0;
    ns = s;
    nf = f;
    nm = 1'b0;
    if (!rstn) begin
      o  = mk(1, 1, 0, 0, 0, 2'd0);
      ns = 0;
      nf = 0;
    end else if (busy) begin
      o.pcw = 0; o.ifw = 0; o.hold = 1;
      ns = 0; nf = 0; nm = 1'b1;
    end else if (redir) begin
      o.fl = 1; o.bub = 1;
      nf = fc - 1; ns = 0;
    end else if (f > 0) begin
      o.fl = 1; o.bub = 1;
      nf = f - 1;
    end else if (s > 0) begin
      o.pcw = 0; o.ifw = 0; o.bub = 1;
      ns = s - 1;
    end else if (lu) begin
      o.pcw = 0; o.ifw = 0; o.bub = 1;
      ns = ll - 1;
    end
  endfunction

  task automatic checkOutput(input string name, input int i, input outs_t e);
    outs_t a;
    a = actual(i);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got pcw/ifw/flush/bubble/hold=%b%b%b%b%b state=%0d, required %b%b%b%b%b state=%0d (t=%0t)",
               name, i, a.pcw, a.ifw, a.fl, a.bub, a.hold, a.st,
               e.pcw, e.ifw, e.fl, e.bub, e.hold, e.st, $time);
    end
  endtask

  // Advance the model on every falling edge; clear it on reset.
  always @(negedge clk or negedge reset) begin
    outs_t o;
    int ns, nf;
    bit nm;
    for (int i = 0; i < 3; i++) begin
      evalModel(fcTab[i], llTab[i], sL[i], fL[i], inM[i], reset, memBusy,
                redirect, luNow(), o, ns, nf, nm);
`ifdef HAZARD_PERF_CNT_EN
      if (!reset) begin
        mStall[i] = 0;
        mFlush[i] = 0;
      end else if (clk == 1'b0) begin
        if (!o.pcw && mStall[i] < 3) mStall[i]++;
        if (o.fl && mFlush[i] < 3) mFlush[i]++;
      end
`endif
      sL[i]  = ns;
      fL[i]  = nf;
      inM[i] = nm;
    end
  end

  // Compare every instance against the model once per cycle, mid-way
  // between input change and the falling edge.
  always begin
    outs_t e;
    int ns, nf;
    bit nm;
    @(posedge clk);
    #4;
    for (int i = 0; i < 3; i++) begin
      evalModel(fcTab[i], llTab[i], sL[i], fL[i], inM[i], reset, memBusy,
                redirect, luNow(), e, ns, nf, nm);
      checkOutput("model", i, e);
`ifdef HAZARD_PERF_CNT_EN
      vectors++;
      if (stallCnt[i] !== 2'(mStall[i]) || flushCnt[i] !== 2'(mFlush[i])) begin
        miscompares++;
        $display("[TB] FAIL perf_counts dut%0d: got stall=%0d flush=%0d, required stall=%0d flush=%0d",
                 i, stallCnt[i], flushCnt[i], mStall[i], mFlush[i]);
      end
`endif
    end
  end

  // Drive one cycle of inputs just after the rising edge, then wait until
  // the sampling point so literal checks can follow directly.
  task automatic applyStimulus(input bit rstn, input logic [4:0] a,
                               input logic [4:0] b, input bit u,
                               input bit mr, input bit rw,
                               input logic [4:0] d, input bit redir,
                               input bit busy);
    @(posedge clk);
    #1;
    reset    = rstn;
    rs1      = a;
    rs2      = b;
    usesRs2  = u;
    memread  = mr;
    regwrite = rw;
    rd       = d;
    redirect = redir;
    memBusy  = busy;
    #3;
  endtask

  task automatic idle();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  // Directed sequences with literal expectations, then randomized traffic.
  initial begin
    outs_t passThru, dflt;
    passThru = mk(1, 1, 0, 0, 0, 2'd0);
    dflt     = mk(1, 1, 0, 0, 0, 2'd0);
    reset = 0; rs1 = 0; rs2 = 0; usesRs2 = 0; memread = 0; regwrite = 0;
    rd = 0; redirect = 0; memBusy = 0;

    applyStimulus(0, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 1);
    checkOutput("reset_passthru", 0, passThru);
    checkOutput("reset_passthru", 1, passThru);
    idle();
    checkOutput("after_reset", 0, dflt);

    applyStimulus(1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0);
    checkOutput("lu_detect", 0, mk(0, 0, 0, 1, 0, 2'd0));
    checkOutput("lu_detect", 1, mk(0, 0, 0, 1, 0, 2'd0));
    idle();
    checkOutput("lat1_release", 1, dflt);
    checkOutput("lat3_hold1", 0, mk(0, 0, 0, 1, 0, 2'd1));
    idle();
    checkOutput("lat3_hold2", 0, mk(0, 0, 0, 1, 0, 2'd1));
    idle();
    checkOutput("lat3_done", 0, dflt);

    applyStimulus(1, 5'd0, 5'd0, 0, 1, 1, 5'd0, 0, 0);
    checkOutput("rd_x0", 0, dflt);
    applyStimulus(1, 5'd3, 5'd5, 0, 1, 1, 5'd5, 0, 0);
    checkOutput("rs2_unused", 0, dflt);
    applyStimulus(1, 5'd3, 5'd5, 1, 1, 1, 5'd5, 0, 0);
    checkOutput("rs2_used", 1, mk(0, 0, 0, 1, 0, 2'd0));
    repeat (3) idle();

    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    checkOutput("redir_c1", 0, mk(1, 1, 1, 1, 0, 2'd0));
    idle();
    checkOutput("redir_c2", 0, mk(1, 1, 1, 1, 0, 2'd3));
    checkOutput("redir_fc1", 1, dflt);
    idle();
    checkOutput("redir_c3", 0, dflt);
    repeat (2) idle();

    applyStimulus(1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 1);
    checkOutput("busy_c1", 1, mk(0, 0, 0, 0, 1, 2'd0));
    repeat (3) begin
      applyStimulus(1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 1);
      checkOutput("busy_wait", 1, mk(0, 0, 0, 0, 1, 2'd2));
    end
    applyStimulus(1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0);
    checkOutput("busy_release_bubble", 1, mk(0, 0, 0, 1, 0, 2'd2));
    idle();
    checkOutput("busy_run", 1, dflt);
    repeat (3) idle();

    applyStimulus(1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0);
    idle();
    checkOutput("ls_before_reset", 0, mk(0, 0, 0, 1, 0, 2'd1));
    applyStimulus(0, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0);
    checkOutput("reset_mid_stall", 0, passThru);
    idle();
    checkOutput("post_reset_run", 0, dflt);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 199) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 9) == 0));
    end

    idle();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline hazard controller sitting on the consumer side of the ID/EX pipeline register. Reads back the ID/EX outputs (memread, destination register, regwrite) and the IF/ID source-register fields, plus the EX-stage redirect and data-memory busy signals. Drives stall/flush/bubble controls into the PC, IF/ID and ID/EX registers. State updates on the negative clock edge, the same edge the pipeline registers use.

Parameters:
FLUSH_CYCLES, 1, cycles if_id_flush stays asserted per redirect, including the detect cycle; range 1..7.
LOAD_LAT, 1, stall cycles per load-use hazard, including the detect cycle; range 1..7.
CNT_W, 16, width of the performance counters (optional feature only).

Ports:
clk  in  1  system clock; state updates on negedge.
reset  in  1  asynchronous, active-low reset.
if_id_rs1  in  5  rs1 field of the instruction in ID.
if_id_rs2  in  5  rs2 field of the instruction in ID.
if_id_uses_rs2  in  1  instruction in ID reads rs2.
id_ex_memread  in  1  Memread output of the ID/EX register.
id_ex_regwrite  in  1  RegWrite output of the ID/EX register.
id_ex_rd  in  5  WriteRegister output of the ID/EX register.
redirect_ex  in  1  EX resolved a taken branch or jal/jalr this cycle.
mem_busy  in  1  data memory not ready; whole pipeline must freeze.
pc_write  out  1  PC register load enable.
if_id_write  out  1  IF/ID load enable.
if_id_flush  out  1  IF/ID loads a NOP.
id_ex_bubble  out  1  ID/EX loads all-zero control (bubble).
id_ex_hold  out  1  ID/EX keeps its current contents.
ctrl_state  out  2  current FSM state (debug).

Behaviour:
- FSM encoding: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3. A 3-bit down-counter cnt handles multi-cycle states.
- Reset (reset=0, async): state=RUN, cnt=0. While reset is low, outputs are forced to pass-through: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, id_ex_hold=0, ctrl_state=0, regardless of inputs.
- load_use = id_ex_memread & id_ex_regwrite & (id_ex_rd!=0) & ((id_ex_rd==if_id_rs1) | (if_id_uses_rs2 & id_ex_rd==if_id_rs2)). Purely combinational, same cycle.
- Outputs are Mealy: decided combinationally from state plus inputs in the same cycle. Zero-cycle latency to the pipeline enables.
- Priority in every state: mem_busy > redirect_ex > load_use.
- RUN, default outputs: pc_write=1, if_id_write=1, all others 0.
- RUN with mem_busy=1: pc_write=0, if_id_write=0, id_ex_hold=1. Next state MEM_WAIT.
- RUN with redirect_ex=1: pc_write=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, next state FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
- RUN with load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_LAT>1, next state LOAD_STALL with cnt=LOAD_LAT-2; otherwise stay in RUN.
- LOAD_STALL: same outputs as the load_use case.
  - cnt==0 returns to RUN; otherwise cnt decrements.
  - redirect_ex=1 here aborts the stall: take the RUN redirect action and transition.
- FLUSH: pc_write=1, if_id_flush=1, id_ex_bubble=1.
  - cnt==0 returns to RUN; otherwise cnt decrements.
  - A new redirect_ex reloads cnt=FLUSH_CYCLES-2.
- MEM_WAIT: pc_write=0, if_id_write=0, id_ex_hold=1 while mem_busy=1. When mem_busy drops, the state returns to RUN that same edge and outputs that cycle follow the RUN rules. No pending stall or flush is lost, because the ID/EX contents were held.
- id_ex_hold and id_ex_bubble are never both 1. if_id_flush and if_id_write=0 are never both asserted.
- rd=x0 never causes a stall.

Optional Feature:
HAZARD_PERF_CNT_EN: adds output ports stall_count[CNT_W-1:0] and flush_count[CNT_W-1:0].
- stall_count increments on every negedge with pc_write=0.
- flush_count increments on every negedge with if_id_flush=1.
- Both saturate at all-ones and reset to 0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset low mid-LOAD_STALL (LOAD_LAT=3) -> state=0, outputs pass-through immediately. After release, RUN with pc_write=1.
- id_ex_memread=1, regwrite=1, rd=5, rs1=5 -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1. With LOAD_LAT=1, next cycle pc_write=1.
- Same as above but rd=0, or rs2=5 with uses_rs2=0 -> no stall, pc_write=1.
- redirect_ex pulse, FLUSH_CYCLES=2 -> if_id_flush=1 for exactly 2 cycles, ctrl_state 0 then 3 then 0.
- mem_busy=1 for 4 cycles together with load_use -> id_ex_hold=1 and bubble=0 for 4 cycles. Then 1 bubble cycle, then RUN.
- With HAZARD_PERF_CNT_EN, CNT_W=2: 5 stall cycles -> stall_count=3 (saturated).
